// File: rtl/spi_slave_if.sv
// spi_slave_if: host-side and SPI-pin signals of the SPI responder
interface spi_slave_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] din_i;
    logic                  load_i;
    logic [DATA_WIDTH-1:0] dout_o;
    logic                  rx_done_tick_o;
    logic                  busy_o;
    logic                  sclk_i;
    logic                  ss_ni;
    logic                  mosi_i;
    logic                  miso_o;
    modport slave (
        input  din_i, load_i, sclk_i, ss_ni, mosi_i,
        output dout_o, rx_done_tick_o, busy_o, miso_o
    );
    modport master (
        output din_i, load_i, sclk_i, ss_ni, mosi_i,
        input  dout_o, rx_done_tick_o, busy_o, miso_o
    );
endinterface

// File: rtl/spi_slave.sv
// spi_slave: mode-0 MSB-first SPI responder oversampling sclk/ss_n/mosi on clk_i
module spi_slave #(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input logic        clk_i,
    input logic        rst_i,
    spi_slave_if.slave bus
);
    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t                r_state, w_next;
    logic [SYNC_STAGES-1:0] r_sclk_s, r_ss_s, r_mosi_s;
    logic                  r_sclk_h, r_ss_h;
    logic [DATA_WIDTH-1:0] r_tx_buf, r_tx_sh, r_rx_sh, r_dout;
    logic [CW-1:0]         r_cnt;
    logic                  r_tick;
    logic                  w_sclk, w_ss, w_mosi;
    logic                  w_sclk_rise, w_sclk_fall, w_ss_fall, w_ss_rise;
    logic [DATA_WIDTH-1:0] w_rx_next;

    assign w_sclk      = r_sclk_s[SYNC_STAGES-1];
    assign w_ss        = r_ss_s[SYNC_STAGES-1];
    assign w_mosi      = r_mosi_s[SYNC_STAGES-1];
    assign w_sclk_rise = w_sclk & ~r_sclk_h;
    assign w_sclk_fall = ~w_sclk & r_sclk_h;
    assign w_ss_fall   = ~w_ss & r_ss_h;
    assign w_ss_rise   = w_ss & ~r_ss_h;
    assign w_rx_next   = {r_rx_sh[DATA_WIDTH-2:0], w_mosi};

    always_ff @(posedge clk_i) begin
        if (!rst_i) r_state <= IDLE;
        else r_state <= w_next;
    end

    always_comb begin
        w_next = (r_state == IDLE) ? (w_ss_fall ? ACTIVE : IDLE) : (w_ss_rise ? IDLE : ACTIVE);
    end

    always_comb begin
        bus.busy_o = (r_state == ACTIVE);
        bus.miso_o = (r_state == ACTIVE) && r_tx_sh[DATA_WIDTH-1];
    end

    // sync/history flops reset to idle levels so leaving reset never looks like an edge
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_sclk_s <= '0;
            r_ss_s   <= '1;
            r_mosi_s <= '0;
            r_sclk_h <= 1'b0;
            r_ss_h   <= 1'b1;
            r_tx_buf <= '0;
            r_tx_sh  <= '0;
            r_rx_sh  <= '0;
            r_dout   <= '0;
            r_cnt    <= '0;
            r_tick   <= 1'b0;
        end else begin
            r_sclk_s <= {r_sclk_s[SYNC_STAGES-2:0], bus.sclk_i};
            r_ss_s   <= {r_ss_s[SYNC_STAGES-2:0], bus.ss_ni};
            r_mosi_s <= {r_mosi_s[SYNC_STAGES-2:0], bus.mosi_i};
            r_sclk_h <= w_sclk;
            r_ss_h   <= w_ss;
            r_tick   <= 1'b0;
            if (bus.load_i) r_tx_buf <= bus.din_i;
            if (r_state == IDLE) begin
                if (w_ss_fall) begin
                    r_tx_sh <= bus.load_i ? bus.din_i : r_tx_buf;
                    r_cnt   <= '0;
                end
            end else if (w_ss_rise) begin
                r_cnt <= '0;
            end else begin
                if (w_sclk_rise) begin
                    r_rx_sh <= w_rx_next;
                    r_cnt   <= (r_cnt == LAST) ? '0 : r_cnt + CW'(1);
                    if (r_cnt == LAST) begin
                        r_dout <= w_rx_next;
                        r_tick <= 1'b1;
                    end
                end
                // a fall at count 0 is a frame boundary: stream the buffer into the next frame
                if (w_sclk_fall) r_tx_sh <= (r_cnt != '0) ? r_tx_sh << 1 : r_tx_buf;
            end
        end
    end

    assign bus.dout_o         = r_dout;
    assign bus.rx_done_tick_o = r_tick;
endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: randomized SPI master against a frame-level model of the responder
module tb_spi_slave;
    localparam int DW = 8;
    localparam int S  = 2;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic [DW-1:0] m_buf;
    logic [DW-1:0] last_rx;
    logic [DW-1:0] q[$];

    spi_slave_if #(.DATA_WIDTH(DW)) bus ();

    spi_slave #(.DATA_WIDTH(DW), .SYNC_STAGES(S)) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (rst && bus.rx_done_tick_o) begin
            if (q.size() == 0) check("tick_unexpected", 1, 0);
            else check("dout", bus.dout_o, q.pop_front());
        end
    end

    task automatic load(input logic [DW-1:0] v);
        bus.din_i  = v;
        bus.load_i = 1'b1;
        cyc(1);
        bus.load_i = 1'b0;
        bus.din_i  = DW'($urandom);
        m_buf      = v;
    endtask

    task automatic xfer(input logic [DW-1:0] mo, input int nb, input int hp, input int lb,
                        input logic [DW-1:0] lv, output logic [DW-1:0] mi);
        int tc, tp;
        tc = 0;
        tp = 0;
        mi = '0;
        if (nb == DW) q.push_back(mo);
        for (int b = 0; b < nb; b++) begin
            bus.mosi_i = mo[DW-1-b];
            if (b == lb) begin
                load(lv);
                cyc(hp - 1);
            end else cyc(hp);
            mi = {mi[DW-2:0], bus.miso_o};
            bus.sclk_i = 1'b1;
            for (int j = 1; j <= hp; j++) begin
                @(negedge clk);
                if (bus.rx_done_tick_o) begin
                    tc++;
                    tp = j;
                end
            end
            bus.sclk_i = 1'b0;
        end
        check("tick_count", tc, nb == DW);
        if (nb == DW) begin
            check("tick_latency", tp, S + 1);
            last_rx = mo;
        end
    endtask

    task automatic frame(input logic [DW-1:0] mo, input int hp);
        logic [DW-1:0] exp, mi;
        bus.ss_ni = 1'b0;
        exp = m_buf;
        xfer(mo, DW, hp, -1, '0, mi);
        check("miso_word", mi, exp);
        cyc(hp);
        bus.ss_ni = 1'b1;
        cyc(hp);
        check("dout_held", bus.dout_o, last_rx);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] mi, exp, mo;
        int hp, nb, bad;
        bus.din_i  = '0;
        bus.load_i = 1'b0;
        bus.sclk_i = 1'b0;
        bus.ss_ni  = 1'b0;
        bus.mosi_i = 1'b1;
        rst        = 1'b0;
        m_buf      = '0;
        last_rx    = '0;
        for (int i = 0; i < 3; i++) begin
            bus.sclk_i = ~bus.sclk_i;
            cyc(1);
            check("rst_dout", bus.dout_o, 0);
            check("rst_tick", bus.rx_done_tick_o, 0);
            check("rst_busy", bus.busy_o, 0);
            check("rst_miso", bus.miso_o, 0);
        end
        bus.ss_ni  = 1'b1;
        bus.sclk_i = 1'b0;
        bus.mosi_i = 1'b0;
        cyc(1);
        rst = 1'b1;
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            cyc(1);
            if (bus.busy_o || bus.rx_done_tick_o) bad++;
        end
        check("post_rst_quiet", bad, 0);
        frame(8'h5B, 6);
        load(8'hA5);
        cyc(2);
        bus.ss_ni = 1'b0;
        cyc(S);
        check("busy_early", bus.busy_o, 0);
        cyc(1);
        check("busy_start", bus.busy_o, 1);
        check("miso_first", bus.miso_o, 1);
        xfer(8'h3C, DW, 8, -1, '0, mi);
        check("single_miso", mi, 8'hA5);
        cyc(8);
        bus.ss_ni = 1'b1;
        cyc(S + 2);
        check("busy_end", bus.busy_o, 0);
        check("single_dout", bus.dout_o, 8'h3C);
        load(8'h81);
        bus.ss_ni = 1'b0;
        xfer(8'h11, DW, 8, 3, 8'h7E, mi);
        check("b2b_miso0", mi, 8'h81);
        xfer(8'h22, DW, 8, -1, '0, mi);
        check("b2b_miso1", mi, 8'h7E);
        cyc(8);
        bus.ss_ni = 1'b1;
        cyc(8);
        check("b2b_dout", bus.dout_o, 8'h22);
        bus.ss_ni = 1'b0;
        xfer(8'hFF, 5, 8, -1, '0, mi);
        cyc(8);
        bus.ss_ni = 1'b1;
        cyc(8);
        check("abort_dout", bus.dout_o, 8'h22);
        frame(8'h55, 8);
        check("after_abort", bus.dout_o, 8'h55);
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            bus.sclk_i = ~bus.sclk_i;
            for (int j = 0; j < 6; j++) begin
                cyc(1);
                if (bus.rx_done_tick_o || bus.miso_o || bus.busy_o) bad++;
            end
        end
        check("idle_quiet", bad, 0);
        check("idle_dout", bus.dout_o, 8'h55);
        bus.ss_ni = 1'b0;
        cyc(S);
        bus.din_i  = 8'hC3;
        bus.load_i = 1'b1;
        cyc(1);
        bus.load_i = 1'b0;
        bus.din_i  = 8'h00;
        m_buf      = 8'hC3;
        xfer(8'h6D, DW, 8, -1, '0, mi);
        check("load_at_fall", mi, 8'hC3);
        cyc(8);
        bus.ss_ni = 1'b1;
        cyc(8);
        load(8'h4E);
        frame(8'h96, S + 3);
        check("min_timing", bus.dout_o, 8'h96);
        for (int it = 0; it < 24; it++) begin
            hp = $urandom_range(S + 3, S + 7);
            if ($urandom_range(0, 2) == 0) load(DW'($urandom));
            bus.ss_ni = 1'b0;
            for (int k = $urandom_range(1, 3); k > 0; k--) begin
                mo  = DW'($urandom);
                nb  = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 7) : DW;
                exp = m_buf;
                xfer(mo, nb, hp, ($urandom_range(0, 2) == 0) ? $urandom_range(1, 6) : -1,
                     DW'($urandom), mi);
                if (nb == DW) check("rand_miso", mi, exp);
                else k = 0;
            end
            cyc(hp);
            bus.ss_ni = 1'b1;
            cyc(hp);
            check("rand_dout", bus.dout_o, last_rx);
        end
        cyc(10);
        check("queue_empty", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
